// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared types and helpers for the round-robin multiplier scheduler
package mult_sched_pkg;

    typedef enum logic {eIdle, eFull} mult_sched_state_e;

    // Low bit of requester k's operand slice in a packed operand bus.
    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/mult_rr_arb.sv
// mult_rr_arb: round-robin one-hot arbiter scanning upward from ptr_i with wrap
module mult_rr_arb #(
    parameter int num_req_p = 4,
    localparam int id_w_lp  = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] v_i,
    input  logic [id_w_lp-1:0]   ptr_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [id_w_lp-1:0]   grant_id_o
);

    logic found;
    int   idx;

    // First valid requester at or after ptr_i, wrapping past the top index.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = (int'(ptr_i) + i) % num_req_p;
            if (!found && v_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_id_o   = id_w_lp'(idx);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplier.sv
// multiplier: unsigned full-width combinational multiplier
module multiplier #(
    parameter int width_p = 8
) (
    input  logic [width_p-1:0]   a_i,
    input  logic [width_p-1:0]   b_i,
    output logic [2*width_p-1:0] c_o
);

    logic [2*width_p-1:0] a_ext, b_ext;

    assign a_ext = {{width_p{1'b0}}, a_i};
    assign b_ext = {{width_p{1'b0}}, b_i};
    assign c_o   = a_ext * b_ext;

endmodule

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: shares one multiplier among requesters with round-robin grants and a held result
module mult_rr_scheduler
    import mult_sched_pkg::*;
#(
    parameter int width_p   = 8,
    parameter int num_req_p = 4,
    localparam int id_width = $clog2(num_req_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [num_req_p-1:0]         v_i,
    input  logic [num_req_p*width_p-1:0] a_i,
    input  logic [num_req_p*width_p-1:0] b_i,
    output logic [num_req_p-1:0]         ready_o,
    output logic                         v_o,
    output logic [2*width_p-1:0]         c_o,
    output logic [id_width-1:0]          id_o,
    input  logic                         yumi_i
);

    mult_sched_state_e    state_q, state_d;
    logic [id_width-1:0]  ptr_q, ptr_d, id_q, id_d, grant_id;
    logic [2*width_p-1:0] c_q, c_d, prod;
    logic [num_req_p-1:0] grant;
    logic [width_p-1:0]   a_sel, b_sel;
    logic                 can_accept, accept;

    mult_rr_arb #(.num_req_p(num_req_p)) arb (
        .v_i        (v_i),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign a_sel = a_i[slice_lo(int'(grant_id), width_p) +: width_p];
    assign b_sel = b_i[slice_lo(int'(grant_id), width_p) +: width_p];

    multiplier #(.width_p(width_p)) mul (
        .a_i (a_sel),
        .b_i (b_sel),
        .c_o (prod)
    );

    assign can_accept = (state_q == eIdle) || (state_q == eFull && yumi_i);
    assign ready_o    = can_accept ? grant : '0;
    assign accept     = |ready_o;
    assign v_o        = (state_q == eFull);
    assign c_o        = c_q;
    assign id_o       = id_q;

    // Accept loads a new product and advances the pointer; a bare yumi drains to idle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        c_d     = c_q;
        id_d    = id_q;
        if (accept) begin
            state_d = eFull;
            c_d     = prod;
            id_d    = grant_id;
            ptr_d   = (grant_id == id_width'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
        end else if (state_q == eFull && yumi_i) begin
            state_d = eIdle;
        end
    end

    // State register; reset discards any held result immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eIdle;
            ptr_q   <= '0;
            c_q     <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            c_q     <= c_d;
            id_q    <= id_d;
        end
    end

endmodule
